// File: rtl/hazard_unit.sv
// Pipeline hazard unit: operand forwarding, load/branch/mult-div stall detection,
// IF/ID flush control, a mult/div busy timer and saturating stall/flush counters.
module hazard_unit #(
  parameter int MULDIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  Rs_D,
  input  logic [4:0]  Rt_D,
  input  logic [4:0]  Rs_E,
  input  logic [4:0]  Rt_E,
  input  logic [4:0]  WriteReg_E,
  input  logic [4:0]  WriteReg_M,
  input  logic [4:0]  WriteReg_W,
  input  logic        RegWrite_E,
  input  logic        RegWrite_M,
  input  logic        RegWrite_W,
  input  logic        MemToReg_E,
  input  logic        MemToReg_M,
  input  logic        Branch_D,
  input  logic        BranchTaken_D,
  input  logic        jump,
  input  logic        MulDiv_D,
  input  logic        MulDivRead_D,
  output logic        StallF,
  output logic        StallD,
  output logic        FlushE,
  output logic        FlushD,
  output logic        ForwardA_D,
  output logic        ForwardB_D,
  output logic [1:0]  ForwardA_E,
  output logic [1:0]  ForwardB_E,
  output logic        MulDivBusy,
  output logic        MulDivDone,
  output logic [15:0] StallCount,
  output logic [15:0] FlushCount
);

  localparam int CNT_W = 6;

  typedef enum logic {IDLE, BUSY} md_state_t;

  md_state_t        r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [15:0]      r_stall_cnt, r_flush_cnt;
  logic             w_lwstall, w_branchstall, w_mdstall, w_stall;

  // Register 0 is hardwired to zero, so a write to it never creates a dependency.
  function automatic logic hit(input logic [4:0] dst, input logic [4:0] src);
    return (dst != 5'd0) && (dst == src);
  endfunction

  function automatic logic [1:0] fwd_sel(input logic [4:0] src);
    if (RegWrite_M && hit(WriteReg_M, src))      return 2'b10;
    else if (RegWrite_W && hit(WriteReg_W, src)) return 2'b01;
    else                                         return 2'b00;
  endfunction

  assign ForwardA_E = fwd_sel(Rs_E);
  assign ForwardB_E = fwd_sel(Rt_E);
  assign ForwardA_D = Branch_D & RegWrite_M & hit(WriteReg_M, Rs_D);
  assign ForwardB_D = Branch_D & RegWrite_M & hit(WriteReg_M, Rt_D);

  assign w_lwstall     = MemToReg_E & (hit(WriteReg_E, Rs_D) | hit(WriteReg_E, Rt_D));
  assign w_branchstall = Branch_D &
                         ((RegWrite_E & (hit(WriteReg_E, Rs_D) | hit(WriteReg_E, Rt_D))) |
                          (MemToReg_M & (hit(WriteReg_M, Rs_D) | hit(WriteReg_M, Rt_D))));
  assign w_mdstall     = MulDivBusy & (MulDiv_D | MulDivRead_D);
  assign w_stall       = w_lwstall | w_branchstall | w_mdstall;

  assign StallF = w_stall;
  assign StallD = w_stall;
  assign FlushE = w_stall;
  // A pending stall holds the branch in ID, so its flush waits for the operands.
  assign FlushD = (BranchTaken_D | jump) & ~w_stall;

  // Busy is decoded from the state register so reset clears it without a clock edge.
  assign MulDivBusy = (r_state == BUSY);
  assign MulDivDone = (r_state == BUSY) && (r_cnt == '0);

  // NOTE: every output of a combinational block gets a default first; otherwise
  // a path that skips an assignment infers a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      IDLE: if (MulDiv_D && !w_stall) begin
        w_state_nxt = BUSY;
        w_cnt_nxt   = CNT_W'(MULDIV_CYCLES - 1);
      end
      BUSY: if (r_cnt == '0) w_state_nxt = IDLE;
            else             w_cnt_nxt   = r_cnt - 1'b1;
      default: w_state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_stall && r_stall_cnt != 16'hFFFF) r_stall_cnt <= r_stall_cnt + 16'd1;
      if (FlushD  && r_flush_cnt != 16'hFFFF) r_flush_cnt <= r_flush_cnt + 16'd1;
    end
  end

  assign StallCount = r_stall_cnt;
  assign FlushCount = r_flush_cnt;

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a behavioural model.
module tb_hazard_unit;

  localparam int MDC = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  Rs_D, Rt_D, Rs_E, Rt_E, WriteReg_E, WriteReg_M, WriteReg_W;
  logic        RegWrite_E, RegWrite_M, RegWrite_W, MemToReg_E, MemToReg_M;
  logic        Branch_D, BranchTaken_D, jump, MulDiv_D, MulDivRead_D;
  logic        StallF, StallD, FlushE, FlushD, ForwardA_D, ForwardB_D;
  logic [1:0]  ForwardA_E, ForwardB_E;
  logic        MulDivBusy, MulDivDone;
  logic [15:0] StallCount, FlushCount;

  int n_checks = 0;
  int n_errors = 0;

  hazard_unit #(.MULDIV_CYCLES(MDC)) dut (
    .clk(clk), .rst_n(rst_n),
    .Rs_D(Rs_D), .Rt_D(Rt_D), .Rs_E(Rs_E), .Rt_E(Rt_E),
    .WriteReg_E(WriteReg_E), .WriteReg_M(WriteReg_M), .WriteReg_W(WriteReg_W),
    .RegWrite_E(RegWrite_E), .RegWrite_M(RegWrite_M), .RegWrite_W(RegWrite_W),
    .MemToReg_E(MemToReg_E), .MemToReg_M(MemToReg_M),
    .Branch_D(Branch_D), .BranchTaken_D(BranchTaken_D), .jump(jump),
    .MulDiv_D(MulDiv_D), .MulDivRead_D(MulDivRead_D),
    .StallF(StallF), .StallD(StallD), .FlushE(FlushE), .FlushD(FlushD),
    .ForwardA_D(ForwardA_D), .ForwardB_D(ForwardB_D),
    .ForwardA_E(ForwardA_E), .ForwardB_E(ForwardB_E),
    .MulDivBusy(MulDivBusy), .MulDivDone(MulDivDone),
    .StallCount(StallCount), .FlushCount(FlushCount)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic next();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    {Rs_D, Rt_D, Rs_E, Rt_E, WriteReg_E, WriteReg_M, WriteReg_W} = '0;
    {RegWrite_E, RegWrite_M, RegWrite_W, MemToReg_E, MemToReg_M} = '0;
    {Branch_D, BranchTaken_D, jump, MulDiv_D, MulDivRead_D} = '0;
  endtask

  // ---------------- behavioural model ----------------
  // m_rem = cycles of mult/div work still outstanding (0 = idle).
  int m_rem = 0;
  int m_scnt = 0;
  int m_fcnt = 0;

  function automatic bit dep(input logic [4:0] dst, input logic [4:0] a, input logic [4:0] b);
    return dst != 0 && (dst == a || dst == b);
  endfunction

  function automatic logic [1:0] m_fwd(input logic [4:0] src);
    if (RegWrite_M && WriteReg_M != 0 && WriteReg_M == src) return 2'b10;
    if (RegWrite_W && WriteReg_W != 0 && WriteReg_W == src) return 2'b01;
    return 2'b00;
  endfunction

  initial begin : compare
    bit m_busy, m_done, m_stall, m_flush, lw, br;
    forever begin
      @(negedge clk);
      #4;
      if (!rst_n) begin
        m_rem = 0; m_scnt = 0; m_fcnt = 0;
      end
      m_busy  = m_rem > 0;
      m_done  = m_rem == 1;
      lw      = MemToReg_E && dep(WriteReg_E, Rs_D, Rt_D);
      br      = Branch_D && ((RegWrite_E && dep(WriteReg_E, Rs_D, Rt_D)) ||
                             (MemToReg_M && dep(WriteReg_M, Rs_D, Rt_D)));
      m_stall = lw || br || (m_busy && (MulDiv_D || MulDivRead_D));
      m_flush = (BranchTaken_D || jump) && !m_stall;
      check("m_StallF", 16'(StallF), 16'(m_stall));
      check("m_StallD", 16'(StallD), 16'(m_stall));
      check("m_FlushE", 16'(FlushE), 16'(m_stall));
      check("m_FlushD", 16'(FlushD), 16'(m_flush));
      check("m_ForwardA_D", 16'(ForwardA_D),
            16'(Branch_D && RegWrite_M && WriteReg_M != 0 && WriteReg_M == Rs_D));
      check("m_ForwardB_D", 16'(ForwardB_D),
            16'(Branch_D && RegWrite_M && WriteReg_M != 0 && WriteReg_M == Rt_D));
      check("m_ForwardA_E", 16'(ForwardA_E), 16'(m_fwd(Rs_E)));
      check("m_ForwardB_E", 16'(ForwardB_E), 16'(m_fwd(Rt_E)));
      check("m_MulDivBusy", 16'(MulDivBusy), 16'(m_busy));
      check("m_MulDivDone", 16'(MulDivDone), 16'(m_done));
      check("m_StallCount", StallCount, 16'(m_scnt));
      check("m_FlushCount", FlushCount, 16'(m_fcnt));
      @(posedge clk);
      if (rst_n) begin
        if (m_rem > 0)                      m_rem--;
        else if (MulDiv_D && !m_stall)      m_rem = MDC;
        if (m_stall && m_scnt < 65535)      m_scnt++;
        if (m_flush && m_fcnt < 65535)      m_fcnt++;
      end
    end
  end

  // ---------------- directed + random stimulus ----------------
  initial begin : driver
    rst_n = 1'b0;
    clear_inputs();
    next(); #4;
    check("rst_busy", 16'(MulDivBusy), 16'd0);
    check("rst_done", 16'(MulDivDone), 16'd0);
    check("rst_scnt", StallCount, 16'd0);
    check("rst_fcnt", FlushCount, 16'd0);

    next(); rst_n = 1'b1;
    // Load-use stall for three cycles.
    next(); MemToReg_E = 1; WriteReg_E = 5; Rs_D = 5; #4;
    check("lw_stallf", 16'(StallF), 16'd1);
    check("lw_stalld", 16'(StallD), 16'd1);
    check("lw_flushe", 16'(FlushE), 16'd1);
    check("lw_scnt0", StallCount, 16'd0);
    next(); #4; check("lw_scnt1", StallCount, 16'd1);
    next(); #4; check("lw_scnt2", StallCount, 16'd2);
    next(); clear_inputs(); #4;
    check("lw_scnt3", StallCount, 16'd3);
    check("lw_gone", 16'(StallD), 16'd0);

    // Forwarding priority.
    next(); RegWrite_M = 1; RegWrite_W = 1; WriteReg_M = 3; WriteReg_W = 3; Rs_E = 3;
    #1; check("fwd_mem", 16'(ForwardA_E), 16'd2);
    WriteReg_M = 0;
    #1; check("fwd_wb", 16'(ForwardA_E), 16'd1);
    WriteReg_W = 0;
    #1; check("fwd_none", 16'(ForwardA_E), 16'd0);

    // Branch stall holds the flush until the operand hazard clears.
    next(); clear_inputs();
    Branch_D = 1; BranchTaken_D = 1; RegWrite_E = 1; WriteReg_E = 7; Rt_D = 7; #4;
    check("br_stalld", 16'(StallD), 16'd1);
    check("br_flushd0", 16'(FlushD), 16'd0);
    next(); RegWrite_E = 0; #4;
    check("br_flushd1", 16'(FlushD), 16'd1);
    check("br_fcnt0", FlushCount, 16'd0);
    next(); clear_inputs(); #4;
    check("br_fcnt1", FlushCount, 16'd1);
    check("br_scnt4", StallCount, 16'd4);

    // Load stall beats a taken branch; jump alone never bubbles EX.
    next(); MemToReg_E = 1; WriteReg_E = 9; Rt_D = 9; BranchTaken_D = 1; #4;
    check("lwbr_flushd", 16'(FlushD), 16'd0);
    check("lwbr_stalld", 16'(StallD), 16'd1);
    next(); clear_inputs(); jump = 1; #4;
    check("jmp_flushe", 16'(FlushE), 16'd0);
    check("jmp_flushd", 16'(FlushD), 16'd1);

    // Mult/div: busy four cycles, done on the fourth, reads stall throughout.
    next(); clear_inputs(); MulDiv_D = 1; #4;
    check("md_issue_busy", 16'(MulDivBusy), 16'd0);
    next(); MulDiv_D = 0; MulDivRead_D = 1;
    for (int i = 1; i <= 4; i++) begin
      #4;
      check("md_busy", 16'(MulDivBusy), 16'd1);
      check("md_done", 16'(MulDivDone), 16'(i == 4));
      check("md_stall", 16'(StallD), 16'd1);
      next();
    end
    #4;
    check("md_idle_busy", 16'(MulDivBusy), 16'd0);
    check("md_idle_stall", 16'(StallD), 16'd0);

    // Reset two cycles into BUSY aborts the operation.
    next(); clear_inputs(); MulDiv_D = 1;
    next(); MulDiv_D = 0;
    next(); #4; check("abort_pre_busy", 16'(MulDivBusy), 16'd1);
    next(); rst_n = 0; #4;
    check("abort_busy", 16'(MulDivBusy), 16'd0);
    check("abort_done", 16'(MulDivDone), 16'd0);
    check("abort_scnt", StallCount, 16'd0);
    check("abort_fcnt", FlushCount, 16'd0);
    next(); rst_n = 1;
    for (int i = 0; i < 5; i++) begin
      #4; check("abort_no_done", 16'(MulDivDone), 16'd0);
      next();
    end

    // First edge out of reset accepts an issue.
    rst_n = 0;
    next(); rst_n = 1; MulDiv_D = 1; #4;
    check("post_rst_idle", 16'(MulDivBusy), 16'd0);
    next(); MulDiv_D = 0; #4;
    check("post_rst_busy", 16'(MulDivBusy), 16'd1);

    // Randomized traffic with small register numbers to provoke matches.
    for (int n = 0; n < 4000; n++) begin
      next();
      rst_n         = ($urandom_range(0, 199) != 0);
      Rs_D          = 5'($urandom_range(0, 7));
      Rt_D          = 5'($urandom_range(0, 7));
      Rs_E          = 5'($urandom_range(0, 7));
      Rt_E          = 5'($urandom_range(0, 7));
      WriteReg_E    = 5'($urandom_range(0, 7));
      WriteReg_M    = 5'($urandom_range(0, 7));
      WriteReg_W    = 5'($urandom_range(0, 7));
      RegWrite_E    = 1'($urandom);
      RegWrite_M    = 1'($urandom);
      RegWrite_W    = 1'($urandom);
      MemToReg_E    = ($urandom_range(0, 3) == 0);
      MemToReg_M    = ($urandom_range(0, 3) == 0);
      Branch_D      = 1'($urandom);
      BranchTaken_D = 1'($urandom);
      jump          = ($urandom_range(0, 3) == 0);
      MulDiv_D      = ($urandom_range(0, 3) == 0);
      MulDivRead_D  = ($urandom_range(0, 2) == 0);
    end

    // Stall counter saturation.
    next(); rst_n = 0; clear_inputs();
    next(); rst_n = 1; MemToReg_E = 1; WriteReg_E = 5; Rs_D = 5;
    repeat (65540) next();
    #4; check("sat_scnt", StallCount, 16'hFFFF);
    next(); #4; check("sat_hold", StallCount, 16'hFFFF);
    check("sat_fcnt", FlushCount, 16'd0);

    next();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 The block SHALL have parameter MULDIV_CYCLES, default 32, giving multiply/divide latency in cycles; legal range is 2..64.
REQ-002 The block SHALL have one clock, clk, and an asynchronous active-low reset, rst_n; all state SHALL be clocked on posedge clk.
REQ-003 The block SHALL have the following ports; inputs are listed before outputs, and clock and reset are listed first:
- clk  in  1  pipeline clock
- rst_n  in  1  async active-low reset
- Rs_D, Rt_D  in  5 each  ID-stage source registers
- Rs_E, Rt_E  in  5 each  EX-stage source registers
- WriteReg_E, WriteReg_M, WriteReg_W  in  5 each  destination register per stage
- RegWrite_E, RegWrite_M, RegWrite_W  in  1 each  destination write enable per stage
- MemToReg_E, MemToReg_M  in  1 each  load in EX / MEM
- Branch_D  in  1  branch in ID
- BranchTaken_D  in  1  branch resolved taken in ID
- jump  in  1  jump in ID
- MulDiv_D  in  1  mult/div issue in ID
- MulDivRead_D  in  1  mfhi/mflo in ID
- StallF, StallD  out  1 each  hold PC and IF/ID
- FlushE  out  1  bubble into ID/EX
- FlushD  out  1  clear IF/ID
- ForwardA_D, ForwardB_D  out  1 each  ID branch-comparator forward from MEM
- ForwardA_E, ForwardB_E  out  2 each  EX ALU operand select
- MulDivBusy  out  1  mult/div in progress
- MulDivDone  out  1  one-cycle completion pulse
- StallCount, FlushCount  out  16 each  saturating performance counters

Function
REQ-004 Register 0 SHALL never match; every match term below requires a nonzero destination.
REQ-005 ForwardA_E SHALL be 2'b10 if RegWrite_M and WriteReg_M==Rs_E; else 2'b01 if RegWrite_W and WriteReg_W==Rs_E; else 2'b00. MEM priority over WB.
REQ-006 ForwardB_E SHALL follow the same rule as REQ-005 using Rt_E.
REQ-007 ForwardA_D SHALL be Branch_D & RegWrite_M & (WriteReg_M==Rs_D); ForwardB_D likewise with Rt_D.
REQ-008 lwstall SHALL be MemToReg_E & (WriteReg_E==Rs_D | WriteReg_E==Rt_D).
REQ-009 branchstall SHALL be Branch_D & ((RegWrite_E & WriteReg_E in {Rs_D,Rt_D}) | (MemToReg_M & WriteReg_M in {Rs_D,Rt_D})).
REQ-010 mdstall SHALL be MulDivBusy & (MulDiv_D | MulDivRead_D).
REQ-011 StallF, StallD and FlushE SHALL each equal lwstall | branchstall | mdstall, combinationally in the same cycle.
REQ-012 FlushD SHALL be (BranchTaken_D | jump) & ~StallD; a stall suppresses the flush until the branch operands resolve.
REQ-013 FlushE SHALL NOT assert for jump alone; the ID/EX register handles jump squashing itself.
REQ-014 The mult/div state machine SHALL have two states:
- IDLE -> BUSY when MulDiv_D & ~StallD; counter loads MULDIV_CYCLES-1.
- BUSY: counter decrements by 1 per cycle.
- BUSY with counter==0 -> IDLE; MulDivDone=1 for exactly that cycle.
REQ-015 MulDivBusy SHALL be 1 exactly while state==BUSY.
REQ-016 In the BUSY->IDLE cycle, mdstall SHALL still assert, and a waiting MulDiv_D SHALL issue on the following cycle; there SHALL be no back-to-back issue in the done cycle.
REQ-017 StallCount SHALL increment on each clock with StallD=1 and hold at 16'hFFFF; it SHALL NOT wrap.
REQ-018 FlushCount SHALL increment on each clock with FlushD=1 and saturate at 16'hFFFF.
REQ-019 When an lwstall and a taken branch occur together, stall SHALL win: FlushD=0 and StallD=1.

Reset
REQ-020 While rst_n=0, regardless of clk: state=IDLE, counter=0, MulDivBusy=0, MulDivDone=0, StallCount=0, FlushCount=0.
REQ-021 The combinational outputs SHALL follow their inputs during reset, with the mdstall term forced to 0.
REQ-022 Reset asserted mid-BUSY SHALL abort the operation; no MulDivDone pulse SHALL follow.
REQ-023 After reset, the first posedge with rst_n=1 SHALL be able to accept a MulDiv_D issue.

Verification
REQ-024 Scenario: MemToReg_E=1, WriteReg_E=5, Rs_D=5 -> StallF=StallD=FlushE=1, StallCount +1 per cycle.
REQ-025 Scenario: RegWrite_M=1, RegWrite_W=1, WriteReg_M=WriteReg_W=Rs_E=3 -> ForwardA_E=2'b10; with WriteReg_M=0 -> ForwardA_E=2'b01; with WriteReg_W=0 as well -> 2'b00.
REQ-026 Scenario: MULDIV_CYCLES=4, MulDiv_D pulse -> MulDivBusy high for 4 cycles, MulDivDone high on the 4th cycle only; MulDivRead_D held high stalls exactly those 4 cycles.
REQ-027 Scenario: Branch_D=1, BranchTaken_D=1, RegWrite_E=1, WriteReg_E=Rt_D=7 -> StallD=1, FlushD=0; on the next cycle with the hazard gone -> FlushD=1.
REQ-028 Scenario: rst_n pulled low 2 cycles into BUSY -> MulDivBusy=0 immediately, no MulDivDone, counters=0.
REQ-029 Scenario: StallD held high for 65540 cycles -> StallCount=16'hFFFF and remains there.
